// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types for the SRAM arbiter.
//   state_t : access FSM states (IDLE, ACC, DONE)
//   grant_t : which requester owns an access (GNT_REC recorder, GNT_PLY player)
//   CNT_W   : width of the strobe-hold counter (WAIT_CYC ranges 1..7)
package sram_arb_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_REC = 1'b0,
    GNT_PLY = 1'b1
  } grant_t;

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational two-way picker.
//   rec_req, ply_req : pending requests
//   favour           : requester that wins when both are pending
//   grant            : selected requester (meaningful only when valid)
//   valid            : at least one request pending
// A lone request always wins; favour only breaks ties.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic   rec_req,
  input  logic   ply_req,
  input  grant_t favour,
  output grant_t grant,
  output logic   valid
);

  always_comb begin
    valid = rec_req | ply_req;
    grant = GNT_REC;
    if (rec_req && ply_req) begin
      grant = favour;
    end else if (ply_req) begin
      grant = GNT_PLY;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between a recorder (writes) and
// a player (reads). Each access is IDLE -> ACC (WAIT_CYC cycles) -> DONE,
// with a one-cycle ack in DONE.
//   i_clk, i_rst                       : clock, async active-high reset
//   i_rec_req/addr/wdata, o_rec_ack    : recorder write port
//   i_ply_req/addr, o_ply_ack/rdata    : player read port
//   o_SRAM_ADDR, io_SRAM_DQ, o_SRAM_*_N: SRAM pins (controls all registered)
// Build option: define SRAM_ARB_REC_PRIO_EN to give the recorder fixed
// priority on simultaneous requests (no round-robin pointer); otherwise
// simultaneous requests alternate, starting with the recorder after reset.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rec_req,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_wdata,
  output logic              o_rec_ack,
  input  logic              i_ply_req,
  input  logic [ADDR_W-1:0] i_ply_addr,
  output logic              o_ply_ack,
  output logic [DATA_W-1:0] o_ply_rdata,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  grant_t            gnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              dq_oe_reg;
  logic              ce_n_reg;
  logic              oe_n_reg;
  logic              we_n_reg;
  logic              rec_ack_reg;
  logic              ply_ack_reg;

  grant_t            favour;
  grant_t            pick_grant;
  logic              pick_valid;

`ifdef SRAM_ARB_REC_PRIO_EN
  assign favour = GNT_REC;
`else
  // Requester that wins the next tie: the one not granted last.
  grant_t favour_reg;
  assign favour = favour_reg;
`endif

  sram_arb_pick u_pick (
    .rec_req (i_rec_req),
    .ply_req (i_ply_req),
    .favour  (favour),
    .grant   (pick_grant),
    .valid   (pick_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      gnt_reg     <= GNT_REC;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      dq_oe_reg   <= 1'b0;
      ce_n_reg    <= 1'b1;
      oe_n_reg    <= 1'b1;
      we_n_reg    <= 1'b1;
      rec_ack_reg <= 1'b0;
      ply_ack_reg <= 1'b0;
`ifndef SRAM_ARB_REC_PRIO_EN
      favour_reg  <= GNT_REC;
`endif
    end else begin
      rec_ack_reg <= 1'b0;
      ply_ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg <= ACC;
            cnt_reg   <= CNT_W'(WAIT_CYC - 1);
            gnt_reg   <= pick_grant;
            ce_n_reg  <= 1'b0;
`ifndef SRAM_ARB_REC_PRIO_EN
            favour_reg <= (pick_grant == GNT_REC) ? GNT_PLY : GNT_REC;
`endif
            if (pick_grant == GNT_REC) begin
              addr_reg  <= i_rec_addr;
              wdata_reg <= i_rec_wdata;
              we_n_reg  <= 1'b0;
              dq_oe_reg <= 1'b1;
            end else begin
              addr_reg  <= i_ply_addr;
              oe_n_reg  <= 1'b0;
            end
          end
        end
        ACC: begin
          if (cnt_reg == '0) begin
            // Last strobe edge: release strobes, capture read data, raise ack.
            state_reg <= DONE;
            ce_n_reg  <= 1'b1;
            oe_n_reg  <= 1'b1;
            we_n_reg  <= 1'b1;
            if (gnt_reg == GNT_PLY) begin
              rdata_reg   <= io_SRAM_DQ;
              ply_ack_reg <= 1'b1;
            end else begin
              rec_ack_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        DONE: begin
          // Write data was held through DONE for hold time; release bus now.
          state_reg <= IDLE;
          dq_oe_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign io_SRAM_DQ  = dq_oe_reg ? wdata_reg : {DATA_W{1'bz}};
  assign o_SRAM_ADDR = addr_reg;
  assign o_SRAM_CE_N = ce_n_reg;
  assign o_SRAM_OE_N = oe_n_reg;
  assign o_SRAM_WE_N = we_n_reg;
  // Full-word accesses only: byte lanes follow chip enable.
  assign o_SRAM_LB_N = ce_n_reg;
  assign o_SRAM_UB_N = ce_n_reg;
  assign o_rec_ack   = rec_ack_reg;
  assign o_ply_ack   = ply_ack_reg;
  assign o_ply_rdata = rdata_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter. u_dut uses WAIT_CYC=1
// with a read/write SRAM model; u_dut3 uses WAIT_CYC=3 with a write-only
// model for chained-write timing.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- WAIT_CYC = 1 instance ----------------
  logic        rst;
  logic        rec_req, ply_req;
  logic [19:0] rec_addr, ply_addr;
  logic [15:0] rec_wdata;
  logic        rec_ack, ply_ack;
  logic [15:0] ply_rdata;
  logic [19:0] sram_addr;
  wire  [15:0] dq;
  logic        we_n, ce_n, oe_n, lb_n, ub_n;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(1)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_rec_req(rec_req), .i_rec_addr(rec_addr), .i_rec_wdata(rec_wdata),
    .o_rec_ack(rec_ack),
    .i_ply_req(ply_req), .i_ply_addr(ply_addr),
    .o_ply_ack(ply_ack), .o_ply_rdata(ply_rdata),
    .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(dq),
    .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
    .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  logic [15:0] mem [0:255];
  assign dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (!ce_n && !we_n) mem[sram_addr[7:0]] <= dq;
  end

  // ---------------- WAIT_CYC = 3 instance ----------------
  logic        rst3;
  logic        rec_req3, ply_req3;
  logic [19:0] rec_addr3, ply_addr3;
  logic [15:0] rec_wdata3;
  logic        rec_ack3, ply_ack3;
  logic [15:0] ply_rdata3;
  logic [19:0] sram_addr3;
  wire  [15:0] dq3;
  logic        we_n3, ce_n3, oe_n3, lb_n3, ub_n3;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst3),
    .i_rec_req(rec_req3), .i_rec_addr(rec_addr3), .i_rec_wdata(rec_wdata3),
    .o_rec_ack(rec_ack3),
    .i_ply_req(ply_req3), .i_ply_addr(ply_addr3),
    .o_ply_ack(ply_ack3), .o_ply_rdata(ply_rdata3),
    .o_SRAM_ADDR(sram_addr3), .io_SRAM_DQ(dq3),
    .o_SRAM_WE_N(we_n3), .o_SRAM_CE_N(ce_n3), .o_SRAM_OE_N(oe_n3),
    .o_SRAM_LB_N(lb_n3), .o_SRAM_UB_N(ub_n3)
  );

  logic [15:0] mem3 [0:255];
  always @(posedge clk) begin
    if (!ce_n3 && !we_n3) mem3[sram_addr3[7:0]] <= dq3;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // One access on u_dut; observes cycles N+0..N+11 where N is the cycle the
  // request is first presented. Results are compared by the caller.
  task automatic run_access(input bit wr, input logic [19:0] a, input logic [15:0] d,
                            input logic [15:0] guard,
                            output int ack_k, output int strobe_n,
                            output logic [15:0] rdat, output bit bus_bad,
                            output bit wrong_ack, output logic [19:0] acc_addr,
                            output logic [15:0] acc_dq);
    @(posedge clk); #1;
    if (wr) begin rec_req = 1'b1; rec_addr = a; rec_wdata = d; end
    else    begin ply_req = 1'b1; ply_addr = a; end
    ack_k = -1; strobe_n = 0; rdat = '0; bus_bad = 1'b0; wrong_ack = 1'b0;
    acc_addr = '0; acc_dq = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rec_req = 1'b0; ply_req = 1'b0;
        acc_addr = sram_addr; acc_dq = dq;
      end
      if (wr ? (!we_n && !ce_n && !lb_n && !ub_n) : (!oe_n && !ce_n && !lb_n && !ub_n))
        strobe_n++;
      if (wr ? ply_ack : rec_ack) wrong_ack = 1'b1;
      if (!wr && oe_n && dq === guard) bus_bad = 1'b1;
      if ((wr ? rec_ack : ply_ack) && ack_k < 0) begin
        ack_k = k; rdat = ply_rdata;
      end
    end
    $display("access %s addr=%05h data=%04h ack_cycle=N+%0d rdata=%04h",
             wr ? "WR" : "RD", a, d, ack_k, rdat);
  endtask

  task automatic test_reset;
    rst = 1'b1; rst3 = 1'b1;
    rec_req = 0; ply_req = 0; rec_addr = '0; ply_addr = '0; rec_wdata = '0;
    rec_req3 = 0; ply_req3 = 0; rec_addr3 = '0; ply_addr3 = '0; rec_wdata3 = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111) begin
      n_bad++; $display("FAIL reset_strobes: got %b want 11111", {ce_n, oe_n, we_n, lb_n, ub_n}); end
    n_cmp++; if (sram_addr !== 20'h0) begin
      n_bad++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
    n_cmp++; if ({rec_ack, ply_ack} !== 2'b00) begin
      n_bad++; $display("FAIL reset_acks: got %b want 00", {rec_ack, ply_ack}); end
    n_cmp++; if (ply_rdata !== 16'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h want 0", ply_rdata); end
    n_cmp++; if ({ce_n3, oe_n3, we_n3} !== 3'b111) begin
      n_bad++; $display("FAIL reset_strobes3: got %b want 111", {ce_n3, oe_n3, we_n3}); end
    rst = 1'b0; rst3 = 1'b0;
    $display("reset released");
  endtask

  task automatic test_single_write;
    int ack_k, sn; logic [15:0] rd; bit bb, wa; logic [19:0] aa; logic [15:0] ad;
    run_access(1'b1, 20'h00012, 16'hBEEF, 16'h0, ack_k, sn, rd, bb, wa, aa, ad);
    n_cmp++; if (ack_k !== 2) begin n_bad++; $display("FAIL wr_ack_latency: got %0d want 2", ack_k); end
    n_cmp++; if (sn !== 1) begin n_bad++; $display("FAIL wr_we_cycles: got %0d want 1", sn); end
    n_cmp++; if (aa !== 20'h00012) begin n_bad++; $display("FAIL wr_addr: got %h want 00012", aa); end
    n_cmp++; if (ad !== 16'hBEEF) begin n_bad++; $display("FAIL wr_dq: got %h want beef", ad); end
    n_cmp++; if (mem[8'h12] !== 16'hBEEF) begin n_bad++; $display("FAIL wr_mem: got %h want beef", mem[8'h12]); end
    n_cmp++; if (wa !== 1'b0) begin n_bad++; $display("FAIL wr_wrong_ack: got %b want 0", wa); end
    // Second write leaves a distinctive value in the write-data register.
    run_access(1'b1, 20'h00040, 16'h1234, 16'h0, ack_k, sn, rd, bb, wa, aa, ad);
    n_cmp++; if (mem[8'h40] !== 16'h1234) begin n_bad++; $display("FAIL wr2_mem: got %h want 1234", mem[8'h40]); end
  endtask

  task automatic test_single_read;
    int ack_k, sn; logic [15:0] rd; bit bb, wa; logic [19:0] aa; logic [15:0] ad;
    run_access(1'b0, 20'h00012, 16'h0, 16'h1234, ack_k, sn, rd, bb, wa, aa, ad);
    n_cmp++; if (ack_k !== 2) begin n_bad++; $display("FAIL rd_ack_latency: got %0d want 2", ack_k); end
    n_cmp++; if (rd !== 16'hBEEF) begin n_bad++; $display("FAIL rd_data: got %h want beef", rd); end
    n_cmp++; if (sn !== 1) begin n_bad++; $display("FAIL rd_oe_cycles: got %0d want 1", sn); end
    n_cmp++; if (aa !== 20'h00012) begin n_bad++; $display("FAIL rd_addr: got %h want 00012", aa); end
    n_cmp++; if (bb !== 1'b0) begin n_bad++; $display("FAIL rd_dq_driven: got %b want 0", bb); end
    n_cmp++; if (wa !== 1'b0) begin n_bad++; $display("FAIL rd_wrong_ack: got %b want 0", wa); end
    // A following write must not disturb the held read data.
    run_access(1'b1, 20'h00041, 16'h5555, 16'h0, ack_k, sn, rd, bb, wa, aa, ad);
    n_cmp++; if (ply_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL rd_hold: got %h want beef", ply_rdata); end
  endtask

  task automatic test_round_robin;
    bit seq [4];
    bit exp_seq [4];
    int n_gnt = 0;
    bit both = 1'b0;
`ifdef SRAM_ARB_REC_PRIO_EN
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    @(negedge clk); rst = 1'b1;
    rec_req = 1'b1; rec_addr = 20'h00060; rec_wdata = 16'h0F0F;
    ply_req = 1'b1; ply_addr = 20'h00012;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 40 && n_gnt < 4; k++) begin
      @(negedge clk);
      if (rec_ack && ply_ack) both = 1'b1;
      if (rec_ack || ply_ack) begin
        seq[n_gnt] = ply_ack;
        $display("grant %0d -> %s", n_gnt, ply_ack ? "PLY" : "REC");
        n_gnt++;
      end
    end
    rec_req = 1'b0; ply_req = 1'b0;
    n_cmp++; if (n_gnt !== 4) begin n_bad++; $display("FAIL rr_count: got %0d want 4", n_gnt); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (i < n_gnt && seq[i] !== exp_seq[i]) begin
        n_bad++; $display("FAIL rr_grant%0d: got %0d want %0d", i, seq[i], exp_seq[i]); end
    end
    n_cmp++; if (both !== 1'b0) begin n_bad++; $display("FAIL rr_double_ack: got %b want 0", both); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    int ack_k = -1; bit saw_rec = 1'b0; logic [15:0] rd = '0;
    @(posedge clk); #1;
    rec_req = 1'b1; rec_addr = 20'h00050; rec_wdata = 16'hA5A5;
    @(negedge clk);           // IDLE sample cycle
    @(negedge clk);           // ACC
    n_cmp++; if (we_n !== 1'b0) begin n_bad++; $display("FAIL rst_pre_we: got %b want 0", we_n); end
    rec_req = 1'b0; ply_req = 1'b1; ply_addr = 20'h00012;
    rst = 1'b1; #1;
    n_cmp++; if ({ce_n, we_n, oe_n, lb_n, ub_n} !== 5'b11111) begin
      n_bad++; $display("FAIL rst_async_strobes: got %b want 11111", {ce_n, we_n, oe_n, lb_n, ub_n}); end
    n_cmp++; if (dq === 16'hA5A5) begin n_bad++; $display("FAIL rst_async_dq: got %h want hi-z", dq); end
    if (rec_ack) saw_rec = 1'b1;
    @(negedge clk);
    if (rec_ack) saw_rec = 1'b1;
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) ply_req = 1'b0;
      if (rec_ack) saw_rec = 1'b1;
      if (ply_ack && ack_k < 0) begin ack_k = k; rd = ply_rdata; end
    end
    $display("reset mid-write, then read ack_cycle=%0d rdata=%04h", ack_k, rd);
    n_cmp++; if (saw_rec !== 1'b0) begin n_bad++; $display("FAIL rst_no_rec_ack: got %b want 0", saw_rec); end
    n_cmp++; if (ack_k !== 2) begin n_bad++; $display("FAIL rst_ply_latency: got %0d want 2", ack_k); end
    n_cmp++; if (rd !== 16'hBEEF) begin n_bad++; $display("FAIL rst_ply_data: got %h want beef", rd); end
    n_cmp++; if (mem[8'h50] === 16'hA5A5) begin n_bad++; $display("FAIL rst_aborted_write: got %h want not a5a5", mem[8'h50]); end
  endtask

  task automatic test_back_to_back;
    int ack_k [8];
    int acks = 0, we_low = 0, oe_low = 0;
    bit overlap = 1'b0, prev_we_low = 1'b0, stray = 1'b0;
    logic [19:0] prev_addr = '0;
    @(posedge clk); #1;
    rec_req3 = 1'b1; rec_addr3 = 20'h0; rec_wdata3 = 16'h1000;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!we_n3) we_low++;
      if (!oe_n3) oe_low++;
      if (ply_ack3 || lb_n3 !== ce_n3 || ub_n3 !== ce_n3) stray = 1'b1;
      if (!we_n3 && prev_we_low && sram_addr3 !== prev_addr) overlap = 1'b1;
      prev_addr = sram_addr3; prev_we_low = !we_n3;
      if (rec_ack3 && acks < 8) begin
        ack_k[acks] = k;
        $display("chained write %0d ack at N+%0d", acks, k);
        acks++;
        if (acks < 8) begin
          rec_addr3 = 20'(acks); rec_wdata3 = 16'h1000 + 16'(acks);
        end else begin
          rec_req3 = 1'b0;
        end
      end
    end
    n_cmp++; if (acks !== 8) begin n_bad++; $display("FAIL chain_acks: got %0d want 8", acks); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (i < acks && ack_k[i] !== 4 + 5 * i) begin
        n_bad++; $display("FAIL chain_ack%0d_cycle: got %0d want %0d", i, ack_k[i], 4 + 5 * i); end
      n_cmp++; if (mem3[i] !== 16'h1000 + 16'(i)) begin
        n_bad++; $display("FAIL chain_mem%0d: got %h want %h", i, mem3[i], 16'h1000 + 16'(i)); end
    end
    n_cmp++; if (we_low !== 24) begin n_bad++; $display("FAIL chain_we_cycles: got %0d want 24", we_low); end
    n_cmp++; if (overlap !== 1'b0) begin n_bad++; $display("FAIL chain_addr_during_we: got %b want 0", overlap); end
    n_cmp++; if (oe_low !== 0) begin n_bad++; $display("FAIL chain_oe_cycles: got %0d want 0", oe_low); end
    n_cmp++; if (stray !== 1'b0) begin n_bad++; $display("FAIL chain_stray_outputs: got %b want 0", stray); end
    n_cmp++; if (ply_rdata3 !== 16'h0) begin n_bad++; $display("FAIL chain_rdata3: got %h want 0", ply_rdata3); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_reset_mid_access();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
